systolic_feed_ctrl: RTL
=======================

# systolic_feed_ctrl

Parametrised operand-feed sequencer for the N×M systolic array. It accepts a start request and issues a wavefront of `load` pulses. Each pulse carries skewed row enables (`A_start_en`) and column enables (`B_start_en`) covering K operand beats per row and column. It then issues N+M-1 drain pulses to flush partial sums, and signals `done`. It replaces the fixed 2×2 test controller and adds a configurable inner dimension, pacing gap, stall, abort and back-to-back tile mode.

## Interface
- `N`, 2, array rows (≥1); width of `A_start_en`
- `M`, 2, array columns (≥1); width of `B_start_en`
- `K`, 4, operand beats per row/column (inner dimension, ≥1)
- `GAP`, 1, idle cycles between successive `load` pulses (≥0)
- `clk`  in  1  single clock; all state changes on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a tile; sampled only in IDLE
- `stall`  in  1  upstream operands not ready; freezes sequencing
- `abort`  in  1  synchronous cancel of current tile
- `auto`  in  1  on tile completion, start the next tile immediately
- `load`  out  1  one-cycle array advance pulse
- `A_start_en`  out  N  row enables, valid only while `load`=1
- `B_start_en`  out  M  column enables, valid only while `load`=1
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle tile-complete pulse

## Operation
- Derived values:
  - F = K + max(N,M) − 1 (feed beats)
  - D = N + M − 1 (drain beats)
  - Beat counter width = clog2(F+D+1); gap counter width = clog2(GAP+1).
- States:
  - IDLE
  - WAIT (gap countdown)
  - LOAD
  - DONE
- IDLE:
  - `start`=1 → WAIT with gap=GAP, beat=0.
  - If GAP=0, go directly to LOAD.
- WAIT:
  - Gap decrements each cycle.
  - On reaching 0 → LOAD.
  - `stall` does not affect WAIT.
- LOAD, `stall`=0:
  - `load`=1.
  - If beat < F: `A_start_en[i]` = (i ≤ beat < i+K) and `B_start_en[j]` = (j ≤ beat < j+K).
  - If beat ≥ F (drain): both enable vectors are 0.
  - Beat increments.
  - If beat = F+D−1 → DONE; otherwise → WAIT, or stay in LOAD if GAP=0.
- LOAD, `stall`=1:
  - `load`=0 and all enables are 0.
  - State and counters hold; the beat is retried on the first cycle with `stall`=0.
- DONE:
  - `done`=1 for exactly one cycle.
  - If `auto`=1 → WAIT (or LOAD if GAP=0) with beat=0, starting a new tile; otherwise → IDLE.
- `abort`=1 in any non-IDLE state:
  - Next state IDLE and counters cleared; no `done` is issued.
  - `abort` overrides `stall`, `auto` and beat completion.
  - The `load` pulse of the current cycle is suppressed.
- `start` while `busy`=1 is ignored (no queueing).
- Reset:
  - Asynchronous reset (`rst`=0) forces IDLE immediately, mid-tile included.
  - All outputs are 0 during reset.
- N=1 or M=1 is legal: the skew collapses and no out-of-range slicing is allowed.

## Timing
- Outputs are Moore-decoded from registered state and counters, with no combinational path from any input except as follows:
  - `stall` gates `load` and the enables in the same cycle.
  - `abort` gates `load` in the same cycle.
- Reset values: `load`=0, `A_start_en`=0, `B_start_en`=0, `busy`=0, `done`=0.
- Latency with no stall:
  - `start` sampled at edge 0 → first `load` at cycle GAP+1.
  - `load` pulses spaced GAP+1 cycles apart.
  - `done` one cycle after the last drain `load`.
- Total tile length: (F+D)(GAP+1)+1 cycles from `start` to `done`, plus stall cycles.
- `busy` rises the cycle after `start` is sampled and falls the cycle after `done`. With `auto`=1, `busy` stays high continuously.

## Test plan
- N=2, M=2, K=3, GAP=1, `start` at cycle 0:
  - `load` at cycles 2, 4, …, 14.
  - A/B enables 01, 11, 11, 10 on the first four pulses, then 00 for three drain pulses.
  - `done` at cycle 15; `busy` low at cycle 16.
- N=4, M=2, K=2, GAP=0:
  - 5 feed + 5 drain consecutive `load` pulses.
  - `A_start_en` sequence 0001, 0011, 0110, 1100, 1000.
  - `B_start_en` sequence 01, 11, 10, 00, 00.
- Same as first scenario with `stall`=1 for 3 cycles at the second LOAD:
  - `load` is held low and enables are 0 during the stall.
  - Enable pattern is unchanged; `done` is delayed by exactly 3 cycles.
- `abort` at the third `load` cycle:
  - That `load` is suppressed, IDLE next cycle, no `done`.
  - A `start` two cycles later runs a full, correct tile.
- `rst` driven low asynchronously mid-feed (between clock edges):
  - All outputs go to 0 immediately.
  - After release, `start` is ignored until the next sampled edge; the tile then runs normally.
- `auto`=1 with N=1, M=3, K=1:
  - Back-to-back tiles; `done` pulses are separated by (3+3)(GAP+1)+1 cycles.
  - `busy` is never low between tiles.
  - `A_start_en` is 1 only on beat 0 of each tile.

Source files
------------

// File: rtl/systolic_feed_ctrl.sv
// Operand-feed sequencer for an N x M systolic array: skewed row/column enables
// over F = K+max(N,M)-1 feed beats, then N+M-1 drain beats, then a done pulse.
module systolic_feed_ctrl #(
    parameter int N   = 2,
    parameter int M   = 2,
    parameter int K   = 4,
    parameter int GAP = 1
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         start_i,
    input  logic         stall_i,
    input  logic         abort_i,
    input  logic         auto_i,
    output logic         load_o,
    output logic [N-1:0] a_start_en_o,
    output logic [M-1:0] b_start_en_o,
    output logic         busy_o,
    output logic         done_o
);

    localparam int MAX_NM = (N > M) ? N : M;
    localparam int F      = K + MAX_NM - 1;
    localparam int D      = N + M - 1;
    localparam int BW     = $clog2(F + D + 1);
    localparam int GW     = (GAP > 0) ? $clog2(GAP + 1) : 1;

    localparam logic [BW-1:0] LAST_BEAT = BW'(F + D - 1);
    localparam logic [BW-1:0] FEED_END  = BW'(F);
    localparam logic [GW-1:0] GAP_INIT  = GW'(GAP);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_LOAD,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    state_t          beat_entry;
    logic [BW-1:0]   beat_q, beat_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [31:0]     beat_w;
    logic            feed;

    // With no pacing gap every beat goes straight back into LOAD.
    assign beat_entry = (GAP == 0) ? S_LOAD : S_WAIT;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            beat_q  <= '0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        gap_d   = gap_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = beat_entry;
                    beat_d  = '0;
                    gap_d   = GAP_INIT;
                end
            end
            S_WAIT: begin
                gap_d = gap_q - GW'(1);
                if (gap_q <= GW'(1)) begin
                    state_d = S_LOAD;
                    gap_d   = '0;
                end
            end
            S_LOAD: begin
                if (!stall_i) begin
                    if (beat_q == LAST_BEAT) begin
                        state_d = S_DONE;
                        beat_d  = '0;
                    end else begin
                        state_d = beat_entry;
                        beat_d  = beat_q + BW'(1);
                        gap_d   = GAP_INIT;
                    end
                end
            end
            S_DONE: begin
                if (auto_i) begin
                    state_d = beat_entry;
                    beat_d  = '0;
                    gap_d   = GAP_INIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Cancel wins over stall, auto-restart and beat completion alike.
        if (abort_i && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            beat_d  = '0;
            gap_d   = '0;
        end
    end

    assign load_o = (state_q == S_LOAD) && !stall_i && !abort_i;
    assign busy_o = (state_q != S_IDLE);
    assign done_o = (state_q == S_DONE);
    assign beat_w = 32'(beat_q);
    assign feed   = load_o && (beat_q < FEED_END);

    // Row i / column j is live for K beats starting at beat i / j (the skew).
    always_comb begin
        a_start_en_o = '0;
        for (int i = 0; i < N; i++) begin
            a_start_en_o[i] = feed && (beat_w >= 32'(i)) && (beat_w < 32'(i + K));
        end
    end

    always_comb begin
        b_start_en_o = '0;
        for (int j = 0; j < M; j++) begin
            b_start_en_o[j] = feed && (beat_w >= 32'(j)) && (beat_w < 32'(j + K));
        end
    end

endmodule
